// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers.
// Gray/binary conversion, usable at any pointer width up to FN_W.
package fifo_pkg;

    localparam int FN_W = 32;

    // Zero-extend narrower values on entry and slice the result on return.
    function automatic logic [FN_W-1:0] bin2gray(
        input logic [FN_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(
        input logic [FN_W-1:0] g
    );
        logic [FN_W-1:0] b;
        b = g;
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the dual-clock FIFO.
// The slave side is the controller; the master side is the consumer.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  rinc;
    logic [ADDR_WIDTH:0]   sync_wr_ptr;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic                  uf_clr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  ren;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   rlevel;
    logic                  runderflow;

    modport slave (
        input  rinc,
        input  sync_wr_ptr,
        input  ae_thresh,
        input  uf_clr,
        output raddr,
        output ren,
        output rptr,
        output rempty,
        output ralmost_empty,
        output rlevel,
        output runderflow
    );

    modport master (
        output rinc,
        output sync_wr_ptr,
        output ae_thresh,
        output uf_clr,
        input  raddr,
        input  ren,
        input  rptr,
        input  rempty,
        input  ralmost_empty,
        input  rlevel,
        input  runderflow
    );

endinterface

// File: rtl/fifo_gray2bin.sv
// Gray to binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO.
// Read pointer, empty/almost-empty flags, fill level and underflow.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input logic           rclk,
    input logic           rrst_n,
    fifo_rd_ctrl_if.slave bus
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    fifo_gray2bin #(
        .W(PW)
    ) u_g2b (
        .gray(bus.sync_wr_ptr),
        .bin (wbin)
    );

    assign bus.ren   = bus.rinc & ~bus.rempty;
    assign bus.raddr = rbin[ADDR_WIDTH-1:0];

    // Flags are computed from the post-read pointer so a read
    // shows up in the same cycle the pointer moves.
    always_comb begin
        rbin_next  = rbin + PW'(bus.ren);
        rgray_next = PW'(bin2gray(FN_W'(rbin_next)));
        level_next = wbin - rbin_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin              <= '0;
            bus.rptr          <= '0;
            bus.rempty        <= 1'b1;
            bus.ralmost_empty <= 1'b1;
            bus.rlevel        <= '0;
            bus.runderflow    <= 1'b0;
        end else begin
            rbin              <= rbin_next;
            bus.rptr          <= rgray_next;
            bus.rempty        <= (rgray_next == bus.sync_wr_ptr);
            bus.ralmost_empty <= (level_next <= bus.ae_thresh);
            bus.rlevel        <= level_next;
            // A new underflow outranks a clear in the same cycle.
            bus.runderflow    <= (bus.rinc & bus.rempty)
                               | (bus.runderflow & ~bus.uf_clr);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: scenario tasks plus a randomized run,
// checked against a word-count model of the FIFO read side.
module tb_fifo_rd_ctrl;

    localparam int AW = 3;

    logic rclk;
    logic rrst_n;
    bit   clk_en;

    fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_rd_ctrl #(
        .ADDR_WIDTH(AW)
    ) dut (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .bus   (bus.slave)
    );

    initial rclk = 1'b0;
    always begin
        #5;
        if (clk_en) rclk = ~rclk;
    end

    int n_chk;
    int n_fail;

    // Model: total words written/read, level as seen by the reader.
    int m_wr;
    int m_rd;
    int m_lvl;
    bit m_uf;
    bit cur_rinc;
    bit cur_clr;

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic drive(input bit ri, input int nwr, input bit clr);
        bus.rinc        = ri;
        bus.uf_clr      = clr;
        m_wr            = m_wr + nwr;
        bus.sync_wr_ptr = g4(m_wr);
        cur_rinc        = ri;
        cur_clr         = clr;
        #1;
    endtask

    task automatic step();
        bit acc;
        acc = cur_rinc && (m_lvl != 0);
        @(posedge rclk);
        if (acc) m_rd = m_rd + 1;
        m_uf  = (cur_rinc && m_lvl == 0) || (m_uf && !cur_clr);
        m_lvl = m_wr - m_rd;
        @(negedge rclk);
    endtask

    task automatic apply_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        m_wr = 0;
        m_rd = 0;
        m_lvl = 0;
        m_uf = 1'b0;
        drive(1'b0, 0, 1'b0);
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        apply_reset();
        bus.ae_thresh = 4'd2;
        drive(1'b0, 5, 1'b0);
        n_chk++;
        if (bus.sync_wr_ptr !== 4'b0111) begin
            n_fail++;
            $display("FAIL fd_ptr: got %b want 0111", bus.sync_wr_ptr);
        end
        step();
        n_chk++;
        if (bus.rempty !== 1'b0 || bus.rlevel !== 4'd5
            || bus.ralmost_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fd_fill: got e=%b l=%0d ae=%b want 0 5 0",
                     bus.rempty, bus.rlevel, bus.ralmost_empty);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 0, 1'b0);
            step();
            n_chk++;
            if (bus.raddr !== 3'(i)) begin
                n_fail++;
                $display("FAIL fd_raddr: got %0d want %0d", bus.raddr, i);
            end
        end
        n_chk++;
        if (bus.rlevel !== 4'd2 || bus.ralmost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fd_ae: got l=%0d ae=%b want 2 1",
                     bus.rlevel, bus.ralmost_empty);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 0, 1'b0);
            step();
        end
        n_chk++;
        if (bus.rempty !== 1'b1 || bus.rlevel !== 4'd0
            || bus.rptr !== 4'b0111) begin
            n_fail++;
            $display("FAIL fd_drain: got e=%b l=%0d p=%b want 1 0 0111",
                     bus.rempty, bus.rlevel, bus.rptr);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev_p;
        logic [2:0] prev_a;
        int wraps;
        bit seen;
        wraps = 0;
        seen = 1'b0;
        drive(1'b0, 1, 1'b0);
        step();
        prev_p = bus.rptr;
        prev_a = bus.raddr;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1, 1'b0);
            n_chk++;
            if (bus.ren !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_ren: got %b want 1", bus.ren);
            end
            step();
            n_chk++;
            if ($countones(prev_p ^ bus.rptr) != 1
                || bus.rptr !== g4(m_rd) || bus.rlevel !== 4'd1) begin
                n_fail++;
                $display("FAIL wrap_step: got p=%b prev=%b l=%0d want p=%b l=1",
                         bus.rptr, prev_p, bus.rlevel, g4(m_rd));
            end
            if (prev_a == 3'd7 && bus.raddr == 3'd0) wraps++;
            if (prev_p == 4'b1000 && bus.rptr == 4'b0000) seen = 1'b1;
            prev_p = bus.rptr;
            prev_a = bus.raddr;
        end
        n_chk++;
        if (wraps < 2 || !seen) begin
            n_fail++;
            $display("FAIL wrap_count: got wraps=%0d seen15to0=%b want >=2 1",
                     wraps, seen);
        end
    endtask

    task automatic test_full();
        apply_reset();
        bus.ae_thresh = 4'd2;
        drive(1'b0, 8, 1'b0);
        step();
        n_chk++;
        if (bus.sync_wr_ptr !== 4'b1100 || bus.rlevel !== 4'd8
            || bus.rempty !== 1'b0 || bus.ralmost_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL full: got w=%b l=%0d e=%b ae=%b want 1100 8 0 0",
                     bus.sync_wr_ptr, bus.rlevel, bus.rempty,
                     bus.ralmost_empty);
        end
    endtask

    task automatic test_underflow();
        logic [3:0] p0;
        apply_reset();
        step();
        p0 = bus.rptr;
        drive(1'b1, 0, 1'b0);
        n_chk++;
        if (bus.ren !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_ren: got %b want 0", bus.ren);
        end
        step();
        n_chk++;
        if (bus.rptr !== p0 || bus.runderflow !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_set: got p=%b uf=%b want %b 1",
                     bus.rptr, bus.runderflow, p0);
        end
        drive(1'b1, 0, 1'b1);
        step();
        n_chk++;
        if (bus.runderflow !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_setwins: got %b want 1", bus.runderflow);
        end
        drive(1'b0, 0, 1'b1);
        step();
        n_chk++;
        if (bus.runderflow !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_clr: got %b want 0", bus.runderflow);
        end
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1, 1'b0);
        step();
        drive(1'b1, 1, 1'b0);
        n_chk++;
        if (bus.ren !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_ren: got %b want 1", bus.ren);
        end
        step();
        n_chk++;
        if (bus.rempty !== 1'b0 || bus.rlevel !== 4'd1) begin
            n_fail++;
            $display("FAIL sim: got e=%b l=%0d want 0 1",
                     bus.rempty, bus.rlevel);
        end
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        int th;
        bit ri;
        bit clr;
        int nw;
        apply_reset();
        th = $urandom_range(0, 8);
        bus.ae_thresh = 4'(th);
        for (int i = 0; i < 300; i++) begin
            ri  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            nw  = (m_wr - m_rd < 8) ? $urandom_range(0, 1) : 0;
            drive(ri, nw, clr);
            n_chk++;
            if (bus.ren !== (ri && m_lvl != 0)) begin
                n_fail++;
                $display("FAIL rnd_ren: got %b want %b",
                         bus.ren, ri && m_lvl != 0);
            end
            step();
            n_chk++;
            if (bus.rlevel !== 4'(m_lvl)
                || bus.rempty !== (m_lvl == 0)
                || bus.ralmost_empty !== (m_lvl <= th)
                || bus.rptr !== g4(m_rd)
                || bus.raddr !== 3'(m_rd)
                || bus.runderflow !== m_uf) begin
                n_fail++;
                $display("FAIL rnd_state: got l=%0d e=%b ae=%b p=%b a=%0d uf=%b want l=%0d p=%b a=%0d uf=%b",
                         bus.rlevel, bus.rempty, bus.ralmost_empty,
                         bus.rptr, bus.raddr, bus.runderflow,
                         m_lvl, g4(m_rd), 3'(m_rd), m_uf);
            end
        end
    endtask

    // Async reset with the clock parked: outputs must clear with no edge.
    task automatic test_reset();
        bus.ae_thresh = 4'd0;
        m_wr = m_rd + 3;
        drive(1'b1, 0, 1'b0);
        step();
        step();
        @(negedge rclk);
        clk_en = 1'b0;
        #2;
        rrst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.rptr !== 4'd0 || bus.raddr !== 3'd0
            || bus.rlevel !== 4'd0 || bus.rempty !== 1'b1
            || bus.ralmost_empty !== 1'b1 || bus.runderflow !== 1'b0
            || bus.ren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got p=%b a=%0d l=%0d e=%b ae=%b uf=%b ren=%b",
                     bus.rptr, bus.raddr, bus.rlevel, bus.rempty,
                     bus.ralmost_empty, bus.runderflow, bus.ren);
        end
        clk_en = 1'b1;
        apply_reset();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clk_en = 1'b1;
        rrst_n = 1'b0;
        bus.ae_thresh = 4'd2;
        m_wr = 0;
        m_rd = 0;
        m_lvl = 0;
        m_uf = 1'b0;
        drive(1'b0, 0, 1'b0);
        test_fill_drain();
        test_wrap();
        test_full();
        test_underflow();
        test_simultaneous();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
